mips_prog_loader: RTL

- Boot-time program loader sitting directly upstream of the pipelined MIPS32 core's 1024x32 unified memory.
- Accepts a framed word stream over a valid/ready handshake: header, N program words, checksum.
- Writes the program words into memory starting at a base address, verifies the checksum, then releases the core via core_run.
- Core IF fetch starts at PC 0 only after core_run rises.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mips_prog_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 platform definitions: memory geometry, boot loader state and
// error encodings used by the program loader and the core.
package mips_pkg;

    localparam int unsigned MEM_DEPTH     = 1024;
    localparam logic [15:0] MAGIC_DEFAULT = 16'hB007;

    // Loader FSM encoding, kept as plain constants so older blocks can reuse it.
    typedef logic [2:0] loader_state_t;
    localparam loader_state_t ST_HDR  = 3'd0;
    localparam loader_state_t ST_DATA = 3'd1;
    localparam loader_state_t ST_CSUM = 3'd2;
    localparam loader_state_t ST_DONE = 3'd3;
    localparam loader_state_t ST_ERR  = 3'd4;

    localparam logic [1:0] ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] ERR_MAGIC   = 2'b01;
    localparam logic [1:0] ERR_SIZE    = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    // True when n words starting at base stay inside a memory of depth words.
    function automatic logic frame_fits(input int unsigned base,
                                        input logic [15:0] n,
                                        input int unsigned depth);
        return (base + 32'(n)) <= depth;
    endfunction

endpackage

// File: rtl/mips_prog_loader.sv
// Boot-time program loader: framed stream (header, N words, checksum) into the
// core's unified memory, then releases core_run. Optional: LOADER_TIMEOUT_EN.
module mips_prog_loader
    import mips_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int unsigned BASE_ADDR   = 0,
    parameter logic [15:0] MAGIC       = MAGIC_DEFAULT,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_run,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output loader_state_t     dbg_state
);

    localparam int unsigned       DEPTH  = 32'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    loader_state_t state;
    logic [15:0]   n_words;
    logic [15:0]   cnt;
    logic [31:0]   acc;
    logic          xfer;
    logic          timeout_hit;

    // Handshake: a word moves on a rising clk1 edge where in_valid && in_ready;
    // in_ready depends only on state, never on in_valid, and the source must
    // hold in_data stable while in_valid is high and in_ready is low.
    assign in_ready  = (state == ST_HDR) || (state == ST_DATA) || (state == ST_CSUM);
    assign xfer      = in_valid && in_ready;
    assign core_run  = (state == ST_DONE);
    assign load_done = (state == ST_DONE);
    assign load_err  = (state == ST_ERR);
    assign dbg_state = state;

`ifdef LOADER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_active;

    // HDR is deliberately excluded: the loader may wait forever for a frame.
    assign idle_active = (state == ST_DATA) || (state == ST_CSUM);
    assign timeout_hit = idle_active && !xfer &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!idle_active || xfer) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    // Timer compiled out; the comparison is constant false.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HDR;
            n_words   <= '0;
            cnt       <= '0;
            acc       <= '0;
            err_code  <= ERR_TIMEOUT;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_HDR: begin
                    if (xfer) begin
                        acc     <= in_data;
                        n_words <= in_data[15:0];
                        cnt     <= '0;
                        if (in_data[31:16] != MAGIC) begin
                            state    <= ST_ERR;
                            err_code <= ERR_MAGIC;
                        end else if (!frame_fits(BASE_ADDR, in_data[15:0], DEPTH)) begin
                            state    <= ST_ERR;
                            err_code <= ERR_SIZE;
                        end else if (in_data[15:0] == 16'd0) begin
                            state <= ST_CSUM;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        acc       <= acc + in_data;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_A + cnt[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        cnt       <= cnt + 16'd1;
                        if (cnt == n_words - 16'd1) begin
                            state <= ST_CSUM;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_ERR;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_CSUM: begin
                    if (xfer) begin
                        if (in_data == acc) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_ERR;
                            err_code <= ERR_CSUM;
                        end
                    end else if (timeout_hit) begin
                        state    <= ST_ERR;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (restart) begin
                        state    <= ST_HDR;
                        err_code <= ERR_TIMEOUT;
                        cnt      <= '0;
                        acc      <= '0;
                    end
                end
                default: begin
                    state <= ST_HDR;
                end
            endcase
        end
    end

endmodule
